// File: rtl/mips_dec_pkg.sv
// Shared widths, count-state encodings and the decode function for the one-hot decoder pipe.
// The decode function works at the widest supported code; callers cast the result to their width.
package mips_dec_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int OUT_W_DEF  = 1 << ADDR_W_DEF;

    // Widest code the shared decode function handles (ADDR_W must not exceed this).
    localparam int ADDR_W_MAX = 8;
    localparam int OUT_W_MAX  = 1 << ADDR_W_MAX;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    function automatic logic [OUT_W_MAX-1:0] onehot(
        input logic [ADDR_W_MAX-1:0] addr,
        input logic                  en,
        input logic                  zmask
    );
        if (!en || (zmask && (addr == '0))) begin
            return '0;
        end
        return OUT_W_MAX'(1) << addr;
    endfunction

endpackage

// File: rtl/onehot_dec_pipe_if.sv
// Handshake bundle of the one-hot decoder pipe: input code, decoded output and scoreboard retire.
// slave is the decoder's view, master the producer/consumer view.
interface onehot_dec_pipe_if
    import mips_dec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    localparam int OUT_W = 1 << ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_en;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_y;
    logic [ADDR_W-1:0] out_addr;
    logic              retire_valid;
    logic [ADDR_W-1:0] retire_addr;
    logic [OUT_W-1:0]  pending;

    modport slave (
        input  in_valid, in_addr, in_en, out_ready, retire_valid, retire_addr,
        output in_ready, out_valid, out_y, out_addr, pending
    );

    modport master (
        output in_valid, in_addr, in_en, out_ready, retire_valid, retire_addr,
        input  in_ready, out_valid, out_y, out_addr, pending
    );

endinterface

// File: rtl/dec_skid_buf.sv
// 2-entry valid/ready buffer; a push into an empty buffer is visible one cycle later.
// o_nfull depends only on the count, so upstream ready never sees i_rdy combinationally.
module dec_skid_buf
    import mips_dec_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    output logic         o_nfull,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         w_pop;

    assign o_vld   = (r_cnt != EMPTY);
    assign o_nfull = (r_cnt != FULL);
    assign o_dat   = r_head;
    assign w_pop   = o_vld & i_rdy;

    // r_head is always the oldest entry; r_tail is only occupied in FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_cnt)
                EMPTY: begin
                    if (i_push) begin
                        r_head <= i_dat;
                        r_cnt  <= ONE;
                    end
                end
                ONE: begin
                    if (i_push && w_pop) begin
                        r_head <= i_dat;
                    end else if (i_push) begin
                        r_tail <= i_dat;
                        r_cnt  <= FULL;
                    end else if (w_pop) begin
                        r_cnt  <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_cnt  <= ONE;
                    end
                end
                default: r_cnt <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/onehot_dec_pipe.sv
// Registered binary-to-one-hot decoder with $zero masking; 1-cycle latency, 1/cycle throughput.
// Stalls when the buffer is full or, with ONEHOT_DEC_SCOREBOARD_EN, when the target register is pending.
module onehot_dec_pipe
    import mips_dec_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit ZERO_MASK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    onehot_dec_pipe_if.slave  bus
);

    localparam int OUT_W = 1 << ADDR_W;
    localparam int DAT_W = ADDR_W + OUT_W;

    logic             w_buf_nfull;
    logic             w_sb_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic [OUT_W-1:0] w_y;
    logic [DAT_W-1:0] w_buf_out;

    assign w_y        = OUT_W'(onehot(ADDR_W_MAX'(bus.in_addr), bus.in_en, ZERO_MASK));
    assign w_in_ready = w_buf_nfull & w_sb_ok;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign bus.in_ready = w_in_ready;

    dec_skid_buf #(
        .W (DAT_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_dat   ({bus.in_addr, w_y}),
        .o_nfull (w_buf_nfull),
        .o_vld   (bus.out_valid),
        .i_rdy   (bus.out_ready),
        .o_dat   (w_buf_out)
    );

    assign bus.out_addr = w_buf_out[DAT_W-1:OUT_W];
    assign bus.out_y    = w_buf_out[OUT_W-1:0];

`ifdef ONEHOT_DEC_SCOREBOARD_EN
    logic [OUT_W-1:0] r_pending;
    logic [OUT_W-1:0] w_set;
    logic [OUT_W-1:0] w_clr;

    // w_y is already the one-hot of in_addr (or zero), so it doubles as the set mask.
    assign w_set = w_accept ? w_y : '0;
    assign w_clr = bus.retire_valid ? (OUT_W'(1) << bus.retire_addr) : '0;

    // Set is applied after clear so a same-cycle set/clear on one bit leaves it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign w_sb_ok     = ~(bus.in_en & r_pending[bus.in_addr]);
    assign bus.pending = r_pending;
`else
    logic w_unused_retire;

    assign w_sb_ok         = 1'b1;
    assign bus.pending     = '0;
    assign w_unused_retire = ^{bus.retire_valid, bus.retire_addr};
`endif

endmodule
